// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// PC source / jump field codes and counter widths.
package pipe_ctrl_pkg;

   localparam int REG_W       = 5;
   localparam int JUMP_W      = 2;
   localparam int PC_SRC_W    = 2;
   localparam int WAIT_CNT_W  = 8;
   localparam int STALL_CNT_W = 3;
   localparam int PERF_W      = 32;

   typedef enum logic [1:0] {
      ST_RUN        = 2'b00,
      ST_LOAD_STALL = 2'b01,
      ST_MEM_WAIT   = 2'b10,
      ST_REDIRECT   = 2'b11
   } state_e;

   localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ    = 2'b00;
   localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [PC_SRC_W-1:0] PC_SRC_JR     = 2'b11;

   localparam logic [JUMP_W-1:0] JUMP_NONE = 2'b00;
   localparam logic [JUMP_W-1:0] JUMP_J    = 2'b01;
   localparam logic [JUMP_W-1:0] JUMP_JR   = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: the instruction in EX is a load whose
// destination is read by the instruction in ID. Register 0 never matches.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_reg_addr,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   output logic             hazard
);

   // hazard when a live source operand matches a pending load destination
   always_comb begin
      hazard = ex_mem_read && (ex_reg_addr != '0) &&
               ((id_uses_rs && (ex_reg_addr == id_rs)) ||
                (id_uses_rt && (ex_reg_addr == id_rt)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / redirect sequencer for the 5-stage pipeline.
// Optional build macro HAZARD_PERF_EN adds stall and flush event counters.
//
// state         | meaning
// --------------+-------------------------------------------------------
// ST_RUN        | normal flow, all banks load
// ST_LOAD_STALL | holding PC/IF_ID, bubbling ID_EX for a load-use hazard
// ST_MEM_WAIT   | data memory busy, whole pipe frozen
// ST_REDIRECT   | one cycle after a taken branch/jump, load-use masked
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_STALL_CYC = 1,
   parameter int unsigned MEM_TIMEOUT    = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_W-1:0]    id_rs,
   input  logic [REG_W-1:0]    id_rt,
   input  logic                id_uses_rs,
   input  logic                id_uses_rt,
   input  logic                ex_MemRead,
   input  logic [REG_W-1:0]    ex_regAddr,
   input  logic                mem_Branch,
   input  logic                mem_ALU_zero,
   input  logic [JUMP_W-1:0]   mem_Jump,
   input  logic                mem_access,
   input  logic                mem_busy,
   output logic                pc_write,
   output logic                if_id_write,
   output logic                id_ex_write,
   output logic                ex_mem_write,
   output logic                if_id_flush,
   output logic                id_ex_flush,
   output logic                ex_mem_flush,
   output logic [PC_SRC_W-1:0] pc_src,
`ifdef HAZARD_PERF_EN
   output logic [PERF_W-1:0]   perf_stall_cnt,
   output logic [PERF_W-1:0]   perf_flush_cnt,
`endif
   output logic                err_timeout
);

   localparam logic [STALL_CNT_W:0]  STALL_LAST = (STALL_CNT_W+1)'(LOAD_STALL_CYC);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

   state_e                  state_q, state_d;
   logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                    err_q, err_d;
   logic [STALL_CNT_W:0]    stall_nxt;
   logic                    lu_hazard;
   logic                    jump_taken, branch_taken, frozen;

   load_use_detect u_load_use_detect (
      .ex_mem_read (ex_MemRead),
      .ex_reg_addr (ex_regAddr),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .hazard      (lu_hazard)
   );

   // next state, counters and Mealy outputs; priority wait > redirect > load-use
   always_comb begin
      state_d      = state_q;
      stall_cnt_d  = stall_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      err_d        = err_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      pc_src       = PC_SRC_SEQ;
      stall_nxt    = {1'b0, stall_cnt_q} + 1'b1;

      jump_taken   = (mem_Jump == JUMP_J) || (mem_Jump == JUMP_JR);
      branch_taken = mem_Branch && mem_ALU_zero;
      // once waiting, only mem_busy keeps the freeze going
      frozen       = (state_q == ST_MEM_WAIT) ? mem_busy : (mem_access && mem_busy);

      if (frozen) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         state_d      = ST_MEM_WAIT;
         stall_cnt_d  = '0;
         // saturate so a very long wait cannot wrap back below the limit
         if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
         if (wait_cnt_d == WAIT_LIMIT) err_d = 1'b1;
      end else begin
         wait_cnt_d = '0;
         if (jump_taken || branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            if (mem_Jump == JUMP_JR)     pc_src = PC_SRC_JR;
            else if (mem_Jump == JUMP_J) pc_src = PC_SRC_JUMP;
            else                         pc_src = PC_SRC_BRANCH;
            state_d     = ST_REDIRECT;
            stall_cnt_d = '0;
         end else if ((state_q == ST_LOAD_STALL) ||
                      ((state_q != ST_REDIRECT) && lu_hazard)) begin
            // the detecting cycle is the first bubble of the stall
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (stall_nxt >= STALL_LAST) begin
               state_d     = ST_RUN;
               stall_cnt_d = '0;
            end else begin
               state_d     = ST_LOAD_STALL;
               stall_cnt_d = stall_nxt[STALL_CNT_W-1:0];
            end
         end else begin
            state_d = ST_RUN;
         end
      end

      // reset holds every bank in bubble regardless of state
      if (!rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         pc_src       = PC_SRC_SEQ;
      end
   end

   // state, counters and sticky timeout flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
      end
   end

   assign err_timeout = err_q;

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
   logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

   // count PC-hold cycles and redirects; both wrap naturally
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (!pc_write)    perf_stall_d = perf_stall_q + 1'b1;
      if (ex_mem_flush) perf_flush_d = perf_flush_q + 1'b1;
   end

   // performance counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_regAddr;
   logic       id_uses_rs, id_uses_rt, ex_MemRead;
   logic       mem_Branch, mem_ALU_zero, mem_access, mem_busy;
   logic [1:0] mem_Jump;
   logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, err_timeout;
   logic [1:0] pc_src;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   int tests  = 0;
   int failed = 0;

   // {writes pc,if_id,id_ex,ex_mem | flushes if_id,id_ex,ex_mem | pc_src}
   logic [8:0] obs;
   assign obs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                 if_id_flush, id_ex_flush, ex_mem_flush, pc_src};

   localparam logic [8:0] O_DEF    = 9'b1111_000_00;
   localparam logic [8:0] O_RST    = 9'b0000_111_00;
   localparam logic [8:0] O_STALL  = 9'b0011_010_00;
   localparam logic [8:0] O_FREEZE = 9'b0000_000_00;
   localparam logic [8:0] O_BR     = 9'b1111_111_01;
   localparam logic [8:0] O_J      = 9'b1111_111_10;
   localparam logic [8:0] O_JR     = 9'b1111_111_11;

   pipeline_hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .ex_MemRead   (ex_MemRead),
      .ex_regAddr   (ex_regAddr),
      .mem_Branch   (mem_Branch),
      .mem_ALU_zero (mem_ALU_zero),
      .mem_Jump     (mem_Jump),
      .mem_access   (mem_access),
      .mem_busy     (mem_busy),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .id_ex_write  (id_ex_write),
      .ex_mem_write (ex_mem_write),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_flush (ex_mem_flush),
      .pc_src       (pc_src),
`ifdef HAZARD_PERF_EN
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt),
`endif
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      ex_MemRead = 1'b0; ex_regAddr = 5'd0;
      mem_Branch = 1'b0; mem_ALU_zero = 1'b0; mem_Jump = 2'b00;
      mem_access = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      #1;
      tests++;
      if (obs !== O_RST || err_timeout !== 1'b0) begin
         failed++;
         $display("FAIL reset_hold obs=%b err=%b exp obs=%b err=0", obs, err_timeout, O_RST);
      end
      next_cycle();
      rst = 1'b1;
      next_cycle();
      tests++;
      if (obs !== O_DEF) begin
         failed++;
         $display("FAIL reset_release obs=%b exp %b", obs, O_DEF);
      end
      // drop reset mid-cycle while running
      rst = 1'b0;
      #1;
      tests++;
      if (obs !== O_RST) begin
         failed++;
         $display("FAIL reset_midrun obs=%b exp %b", obs, O_RST);
      end
      next_cycle();
      rst = 1'b1;
      next_cycle();
      tests++;
      if (obs !== O_DEF) begin
         failed++;
         $display("FAIL reset_midrun_release obs=%b exp %b", obs, O_DEF);
      end
   endtask

   task automatic test_load_use();
      ex_MemRead = 1'b1; ex_regAddr = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
      #1;
      tests++;
      if (obs !== O_STALL) begin
         failed++;
         $display("FAIL load_use_rs obs=%b exp %b", obs, O_STALL);
      end
      next_cycle();
      idle_inputs();
      #1;
      tests++;
      if (obs !== O_DEF) begin
         failed++;
         $display("FAIL load_use_after obs=%b exp %b", obs, O_DEF);
      end
      next_cycle();
      ex_MemRead = 1'b1; ex_regAddr = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
      #1;
      tests++;
      if (obs !== O_DEF) begin
         failed++;
         $display("FAIL load_use_r0 obs=%b exp %b", obs, O_DEF);
      end
      next_cycle();
      idle_inputs();
      ex_MemRead = 1'b1; ex_regAddr = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3;
      #1;
      tests++;
      if (obs !== O_STALL) begin
         failed++;
         $display("FAIL load_use_rt obs=%b exp %b", obs, O_STALL);
      end
      next_cycle();
      idle_inputs();
      ex_MemRead = 1'b1; ex_regAddr = 5'd7; id_rs = 5'd7; id_rt = 5'd7;
      #1;
      tests++;
      if (obs !== O_DEF) begin
         failed++;
         $display("FAIL load_use_unused obs=%b exp %b", obs, O_DEF);
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_branch();
      mem_Branch = 1'b1; mem_ALU_zero = 1'b1;
      #1;
      tests++;
      if (obs !== O_BR) begin
         failed++;
         $display("FAIL branch_taken obs=%b exp %b", obs, O_BR);
      end
      next_cycle();
      idle_inputs();
      ex_MemRead = 1'b1; ex_regAddr = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
      #1;
      tests++;
      if (obs !== O_DEF) begin
         failed++;
         $display("FAIL branch_masks_load_use obs=%b exp %b", obs, O_DEF);
      end
      next_cycle();
      idle_inputs();
      mem_Branch = 1'b1; mem_ALU_zero = 1'b0;
      #1;
      tests++;
      if (obs !== O_DEF) begin
         failed++;
         $display("FAIL branch_not_taken obs=%b exp %b", obs, O_DEF);
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_perf();
`ifdef HAZARD_PERF_EN
      tests++;
      if (perf_stall_cnt !== 32'd2 || perf_flush_cnt !== 32'd1) begin
         failed++;
         $display("FAIL perf_counts stall=%0d flush=%0d exp stall=2 flush=1",
                  perf_stall_cnt, perf_flush_cnt);
      end
`endif
   endtask

   task automatic test_jump();
      mem_Jump = 2'b10; mem_Branch = 1'b1; mem_ALU_zero = 1'b1;
      #1;
      tests++;
      if (obs !== O_JR) begin
         failed++;
         $display("FAIL jump_beats_branch obs=%b exp %b", obs, O_JR);
      end
      next_cycle();
      idle_inputs();
      next_cycle();
      mem_Jump = 2'b01;
      #1;
      tests++;
      if (obs !== O_J) begin
         failed++;
         $display("FAIL jump_j obs=%b exp %b", obs, O_J);
      end
      next_cycle();
      idle_inputs();
      next_cycle();
      mem_Jump = 2'b11;
      #1;
      tests++;
      if (obs !== O_DEF) begin
         failed++;
         $display("FAIL jump_reserved obs=%b exp %b", obs, O_DEF);
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_mem_wait();
      mem_busy = 1'b1;
      #1;
      tests++;
      if (obs !== O_DEF) begin
         failed++;
         $display("FAIL busy_without_access obs=%b exp %b", obs, O_DEF);
      end
      next_cycle();
      mem_access = 1'b1; mem_busy = 1'b1; mem_Branch = 1'b1; mem_ALU_zero = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (obs !== O_FREEZE) begin
            failed++;
            $display("FAIL mem_wait_freeze cyc=%0d obs=%b exp %b", i, obs, O_FREEZE);
         end
         next_cycle();
      end
      mem_busy = 1'b0;
      #1;
      tests++;
      if (obs !== O_BR) begin
         failed++;
         $display("FAIL mem_wait_exit_redirect obs=%b exp %b", obs, O_BR);
      end
      next_cycle();
      idle_inputs();
      #1;
      tests++;
      if (obs !== O_DEF || err_timeout !== 1'b0) begin
         failed++;
         $display("FAIL mem_wait_after obs=%b err=%b exp %b err=0", obs, err_timeout, O_DEF);
      end
      next_cycle();
   endtask

   task automatic test_timeout();
      mem_access = 1'b1; mem_busy = 1'b1;
      for (int i = 0; i < 254; i++) next_cycle();
      tests++;
      if (err_timeout !== 1'b0) begin
         failed++;
         $display("FAIL timeout_early err=%b exp 0", err_timeout);
      end
      next_cycle();
      next_cycle();
      tests++;
      if (err_timeout !== 1'b1 || obs !== O_FREEZE) begin
         failed++;
         $display("FAIL timeout_set err=%b obs=%b exp err=1 obs=%b", err_timeout, obs, O_FREEZE);
      end
      idle_inputs();
      next_cycle();
      tests++;
      if (err_timeout !== 1'b1 || obs !== O_DEF) begin
         failed++;
         $display("FAIL timeout_sticky err=%b obs=%b exp err=1 obs=%b", err_timeout, obs, O_DEF);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (err_timeout !== 1'b0 || obs !== O_RST) begin
         failed++;
         $display("FAIL timeout_reset_clear err=%b obs=%b exp err=0 obs=%b", err_timeout, obs, O_RST);
      end
      next_cycle();
      rst = 1'b1;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_perf();
      test_jump();
      test_mem_wait();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
